// File: rtl/scarv_cop_pkg.sv
// rtl/scarv_cop_pkg.sv - shared state encoding and result codes for the coprocessor dispatcher
package scarv_cop_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } cop_state_t;

    localparam logic [2:0] RES_OK      = 3'd0;
    localparam logic [2:0] RES_ABORT   = 3'd6;
    localparam logic [2:0] RES_TIMEOUT = 3'd7;

endpackage

// File: rtl/scarv_cop_dispatch_timer.sv
// rtl/scarv_cop_dispatch_timer.sv - saturating WAIT-cycle counter with timeout strobe
module scarv_cop_dispatch_timer #(
    parameter int TIMEOUT = 255,
    parameter int TCW     = 8
) (
    input  logic g_clk,
    input  logic g_reset,
    input  logic i_run,
    input  logic i_inc,
    output logic o_expire
);

    // Expiry fires on the WAIT cycle whose increment brings the count to TIMEOUT.
    localparam logic [TCW-1:0] LIMIT = TCW'(TIMEOUT - 1);
    localparam logic [TCW-1:0] SAT   = TCW'(TIMEOUT);

    logic [TCW-1:0] r_cnt;

    // Held at zero outside WAIT so every WAIT entry starts from a cleared count; stops at TIMEOUT.
    always_ff @(posedge g_clk) begin
        if (g_reset || !i_run) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != SAT)) begin
            r_cnt <= r_cnt + TCW'(1);
        end
    end

    assign o_expire = i_inc && (r_cnt >= LIMIT);

endmodule

// File: rtl/scarv_cop_dispatch.sv
// rtl/scarv_cop_dispatch.sv - single-in-flight host to coprocessor instruction dispatcher
module scarv_cop_dispatch
    import scarv_cop_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int TCW     = 8
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        hst_valid,
    output logic        hst_ready,
    input  logic [31:0] hst_insn,
    input  logic [31:0] hst_rs1,
    input  logic        hst_abort,
    output logic        cpu_insn_req,
    input  logic        cop_insn_ack,
    output logic [31:0] cpu_insn_enc,
    output logic [31:0] cpu_rs1,
    output logic        cpu_abort_req,
    input  logic        cop_insn_rsp,
    output logic        cpu_insn_ack,
    input  logic        cop_wen,
    input  logic [4:0]  cop_waddr,
    input  logic [31:0] cop_wdata,
    input  logic [2:0]  cop_result,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic        wb_wen,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic [2:0]  wb_result
);

    cop_state_t  r_state;
    cop_state_t  w_state_nxt;
    logic [31:0] r_insn;
    logic [31:0] r_rs1;
    logic        r_abort_flag;
    logic        r_abort_req;
    logic        r_wb_wen;
    logic [4:0]  r_wb_addr;
    logic [31:0] r_wb_data;
    logic [2:0]  r_wb_result;

    logic w_accept;
    logic w_issue_ack;
    logic w_rsp;
    logic w_timeout;
    logic w_abort_wait;
    logic w_aborted;

    assign hst_ready    = (r_state == ST_IDLE);
    assign cpu_insn_req = (r_state == ST_ISSUE);
    assign cpu_insn_ack = (r_state == ST_WAIT);
    assign wb_valid     = (r_state == ST_WB);

    assign w_accept    = hst_valid && hst_ready;
    assign w_issue_ack = cpu_insn_req && cop_insn_ack;
    assign w_rsp       = cpu_insn_ack && cop_insn_rsp;

    // An abort alongside the issue ack counts as a WAIT abort; only the first one is forwarded.
    assign w_abort_wait = hst_abort && !r_abort_flag && (cpu_insn_ack || w_issue_ack);
    assign w_aborted    = r_abort_flag || (hst_abort && cpu_insn_ack);

    scarv_cop_dispatch_timer #(
        .TIMEOUT (TIMEOUT),
        .TCW     (TCW)
    ) u_timer (
        .g_clk    (g_clk),
        .g_reset  (g_reset),
        .i_run    (cpu_insn_ack),
        .i_inc    (cpu_insn_ack && !cop_insn_rsp),
        .o_expire (w_timeout)
    );

    // State register.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state selection; ack beats abort in ISSUE, response beats timeout in WAIT.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                if (cop_insn_ack)   w_state_nxt = ST_WAIT;
                else if (hst_abort) w_state_nxt = ST_IDLE;
            end
            ST_WAIT:  if (w_rsp || w_timeout) w_state_nxt = ST_WB;
            ST_WB:    if (wb_ready) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Instruction capture, abort tracking and writeback payload registers.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_insn       <= '0;
            r_rs1        <= '0;
            r_abort_flag <= 1'b0;
            r_abort_req  <= 1'b0;
            r_wb_wen     <= 1'b0;
            r_wb_addr    <= '0;
            r_wb_data    <= '0;
            r_wb_result  <= RES_OK;
        end else begin
            r_abort_req <= w_abort_wait;
            if (w_accept) begin
                r_insn       <= hst_insn;
                r_rs1        <= hst_rs1;
                r_abort_flag <= 1'b0;
            end else if (w_abort_wait) begin
                r_abort_flag <= 1'b1;
            end
            if (w_rsp) begin
                if (w_aborted) begin
                    r_wb_wen    <= 1'b0;
                    r_wb_addr   <= '0;
                    r_wb_data   <= '0;
                    r_wb_result <= RES_ABORT;
                end else begin
                    r_wb_wen    <= cop_wen;
                    r_wb_addr   <= cop_waddr;
                    r_wb_data   <= cop_wdata;
                    r_wb_result <= cop_result;
                end
            end else if (w_timeout) begin
                r_wb_wen    <= 1'b0;
                r_wb_addr   <= '0;
                r_wb_data   <= '0;
                r_wb_result <= RES_TIMEOUT;
            end
        end
    end

    assign cpu_insn_enc  = r_insn;
    assign cpu_rs1       = r_rs1;
    assign cpu_abort_req = r_abort_req;
    assign wb_wen        = r_wb_wen;
    assign wb_addr       = r_wb_addr;
    assign wb_data       = r_wb_data;
    assign wb_result     = r_wb_result;

endmodule

// File: tb/tb_scarv_cop_dispatch.sv
// tb/tb_scarv_cop_dispatch.sv - self-checking bench for scarv_cop_dispatch
module tb_scarv_cop_dispatch;

    localparam int TB_TIMEOUT = 4;

    logic        g_clk = 1'b0;
    logic        g_reset;
    logic        hst_valid;
    logic        hst_ready;
    logic [31:0] hst_insn;
    logic [31:0] hst_rs1;
    logic        hst_abort;
    logic        cpu_insn_req;
    logic        cop_insn_ack;
    logic [31:0] cpu_insn_enc;
    logic [31:0] cpu_rs1;
    logic        cpu_abort_req;
    logic        cop_insn_rsp;
    logic        cpu_insn_ack;
    logic        cop_wen;
    logic [4:0]  cop_waddr;
    logic [31:0] cop_wdata;
    logic [2:0]  cop_result;
    logic        wb_valid;
    logic        wb_ready;
    logic        wb_wen;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [2:0]  wb_result;

    int n_vec = 0;
    int n_err = 0;

    scarv_cop_dispatch #(.TIMEOUT(TB_TIMEOUT), .TCW(8)) dut (
        .g_clk         (g_clk),
        .g_reset       (g_reset),
        .hst_valid     (hst_valid),
        .hst_ready     (hst_ready),
        .hst_insn      (hst_insn),
        .hst_rs1       (hst_rs1),
        .hst_abort     (hst_abort),
        .cpu_insn_req  (cpu_insn_req),
        .cop_insn_ack  (cop_insn_ack),
        .cpu_insn_enc  (cpu_insn_enc),
        .cpu_rs1       (cpu_rs1),
        .cpu_abort_req (cpu_abort_req),
        .cop_insn_rsp  (cop_insn_rsp),
        .cpu_insn_ack  (cpu_insn_ack),
        .cop_wen       (cop_wen),
        .cop_waddr     (cop_waddr),
        .cop_wdata     (cop_wdata),
        .cop_result    (cop_result),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_wen        (wb_wen),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .wb_result     (wb_result)
    );

    always #5 g_clk = ~g_clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0b expected %0b", name, $time, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // Transaction-level reference: phase 0 idle, 1 offered to coprocessor, 2 awaiting result, 3 result posted.
    int          m_phase = 0;
    int          m_waits = 0;
    bit          m_aborted = 0;
    bit          m_pulse = 0;
    logic [31:0] m_insn = '0;
    logic [31:0] m_rs1 = '0;
    logic        m_wen = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    logic [2:0]  m_res = '0;

    task automatic model_step();
        bit pulse_n;
        pulse_n = 0;
        if (g_reset) begin
            m_phase = 0; m_aborted = 0; m_insn = '0; m_rs1 = '0;
            m_wen = 1'b0; m_addr = '0; m_data = '0; m_res = '0;
        end else begin
            case (m_phase)
                0: if (hst_valid) begin
                    m_insn = hst_insn; m_rs1 = hst_rs1; m_aborted = 0; m_phase = 1;
                end
                1: if (cop_insn_ack) begin
                    m_phase = 2; m_waits = 0;
                    if (hst_abort) begin m_aborted = 1; pulse_n = 1; end
                end else if (hst_abort) begin
                    m_phase = 0;
                end
                2: begin
                    if (hst_abort && !m_aborted) begin m_aborted = 1; pulse_n = 1; end
                    if (cop_insn_rsp) begin
                        m_phase = 3;
                        if (m_aborted) begin
                            m_wen = 1'b0; m_addr = '0; m_data = '0; m_res = 3'd6;
                        end else begin
                            m_wen = cop_wen; m_addr = cop_waddr; m_data = cop_wdata; m_res = cop_result;
                        end
                    end else begin
                        m_waits++;
                        if (m_waits >= TB_TIMEOUT) begin
                            m_phase = 3; m_wen = 1'b0; m_addr = '0; m_data = '0; m_res = 3'd7;
                        end
                    end
                end
                default: if (wb_ready) m_phase = 0;
            endcase
        end
        m_pulse = pulse_n;
    endtask

    // Advance the reference on each edge, then compare every meaningful output just after it.
    always @(posedge g_clk) begin
        model_step();
        #1;
        chk1("hst_ready", hst_ready, m_phase == 0);
        chk1("cpu_insn_req", cpu_insn_req, m_phase == 1);
        chk1("cpu_insn_ack", cpu_insn_ack, m_phase == 2);
        chk1("wb_valid", wb_valid, m_phase == 3);
        chk1("cpu_abort_req", cpu_abort_req, m_pulse);
        if (m_phase == 1) begin
            chk32("cpu_insn_enc", cpu_insn_enc, m_insn);
            chk32("cpu_rs1", cpu_rs1, m_rs1);
        end
        if (m_phase == 3) begin
            chk1("wb_wen", wb_wen, m_wen);
            chk32("wb_addr", 32'(wb_addr), 32'(m_addr));
            chk32("wb_data", wb_data, m_data);
            chk32("wb_result", 32'(wb_result), 32'(m_res));
        end
    end

    task automatic tick();
        @(negedge g_clk);
    endtask

    initial begin
        g_reset = 1'b1; hst_valid = 1'b0; hst_insn = '0; hst_rs1 = '0; hst_abort = 1'b0;
        cop_insn_ack = 1'b0; cop_insn_rsp = 1'b0; cop_wen = 1'b0; cop_waddr = '0;
        cop_wdata = '0; cop_result = '0; wb_ready = 1'b0;
        repeat (2) tick();
        g_reset = 1'b0;
        chk1("rst_hst_ready", hst_ready, 1'b1);
        chk1("rst_wb_valid", wb_valid, 1'b0);
        chk1("rst_insn_req", cpu_insn_req, 1'b0);
        chk32("rst_wb_data", wb_data, 32'd0);

        // Minimum-latency transaction.
        hst_valid = 1'b1; hst_insn = 32'h0000_002B; hst_rs1 = 32'hDEAD_BEEF;
        cop_insn_ack = 1'b1; cop_insn_rsp = 1'b1;
        cop_wen = 1'b1; cop_waddr = 5'd5; cop_wdata = 32'h1234; cop_result = 3'd0;
        tick();
        hst_valid = 1'b0;
        chk1("lat_req", cpu_insn_req, 1'b1);
        chk32("lat_enc", cpu_insn_enc, 32'h0000_002B);
        chk32("lat_rs1", cpu_rs1, 32'hDEAD_BEEF);
        tick();
        chk1("lat_wait", cpu_insn_ack, 1'b1);
        tick();
        chk1("lat_wb_valid", wb_valid, 1'b1);
        chk1("lat_wb_wen", wb_wen, 1'b1);
        chk32("lat_wb_addr", 32'(wb_addr), 32'd5);
        chk32("lat_wb_data", wb_data, 32'h1234);
        chk32("lat_wb_result", 32'(wb_result), 32'd0);
        wb_ready = 1'b1; cop_insn_ack = 1'b0; cop_insn_rsp = 1'b0;
        tick();
        wb_ready = 1'b0;

        // Issue held for five cycles while the coprocessor withholds its ack.
        hst_valid = 1'b1; hst_insn = 32'hA5A5_0001; hst_rs1 = 32'h1111_2222;
        tick();
        hst_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            hst_insn = $urandom; hst_rs1 = $urandom;
            chk1("hold_req", cpu_insn_req, 1'b1);
            chk32("hold_enc", cpu_insn_enc, 32'hA5A5_0001);
            chk32("hold_rs1", cpu_rs1, 32'h1111_2222);
            if (i == 4) cop_insn_ack = 1'b1;
            tick();
        end
        chk1("hold_wait", cpu_insn_ack, 1'b1);
        cop_insn_ack = 1'b0; cop_insn_rsp = 1'b1;
        tick();
        cop_insn_rsp = 1'b0; wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;

        // Timeout after TB_TIMEOUT waiting cycles; a late response must not disturb the result.
        hst_valid = 1'b1; cop_insn_ack = 1'b1;
        tick();
        hst_valid = 1'b0;
        tick();
        cop_insn_ack = 1'b0;
        for (int i = 0; i < TB_TIMEOUT; i++) begin
            chk1("to_waiting", cpu_insn_ack, 1'b1);
            tick();
        end
        chk1("to_wb_valid", wb_valid, 1'b1);
        chk32("to_result", 32'(wb_result), 32'd7);
        chk1("to_wen", wb_wen, 1'b0);
        chk32("to_data", wb_data, 32'd0);
        cop_insn_rsp = 1'b1; cop_result = 3'd0;
        tick();
        chk32("to_late_rsp", 32'(wb_result), 32'd7);
        cop_insn_rsp = 1'b0; wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;

        // Abort in the second waiting cycle, response then coincides with the timeout point.
        hst_valid = 1'b1; cop_insn_ack = 1'b1;
        tick();
        hst_valid = 1'b0;
        tick();
        cop_insn_ack = 1'b0;
        tick();
        hst_abort = 1'b1;
        tick();
        hst_abort = 1'b0;
        chk1("ab_pulse", cpu_abort_req, 1'b1);
        tick();
        chk1("ab_pulse_end", cpu_abort_req, 1'b0);
        cop_insn_rsp = 1'b1; cop_wen = 1'b1; cop_waddr = 5'd9; cop_result = 3'd0;
        tick();
        cop_insn_rsp = 1'b0;
        chk32("ab_result", 32'(wb_result), 32'd6);
        chk1("ab_wen", wb_wen, 1'b0);

        // Writeback back-pressure, then immediate acceptance of the next instruction.
        for (int i = 0; i < 10; i++) begin
            chk1("bp_valid", wb_valid, 1'b1);
            chk1("bp_hst_ready", hst_ready, 1'b0);
            chk32("bp_result", 32'(wb_result), 32'd6);
            tick();
        end
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        chk1("bp_idle", hst_ready, 1'b1);
        hst_valid = 1'b1; hst_insn = 32'h0BAD_F00D;
        tick();
        hst_valid = 1'b0;
        chk32("bp_next_enc", cpu_insn_enc, 32'h0BAD_F00D);
        hst_abort = 1'b1;
        tick();
        hst_abort = 1'b0;
        chk1("issue_abort_idle", hst_ready, 1'b1);
        chk1("issue_abort_req", cpu_insn_req, 1'b0);

        // Reset while waiting discards the instruction silently.
        hst_valid = 1'b1; cop_insn_ack = 1'b1;
        tick();
        hst_valid = 1'b0;
        tick();
        cop_insn_ack = 1'b0; g_reset = 1'b1; hst_abort = 1'b1;
        tick();
        g_reset = 1'b0; hst_abort = 1'b0;
        chk1("rstw_hst_ready", hst_ready, 1'b1);
        chk1("rstw_wb_valid", wb_valid, 1'b0);
        chk1("rstw_abort_req", cpu_abort_req, 1'b0);

        // Randomized traffic checked against the reference every cycle.
        for (int c = 0; c < 3000; c++) begin
            hst_valid    = 1'($urandom_range(0, 1));
            hst_insn     = $urandom;
            hst_rs1      = $urandom;
            hst_abort    = ($urandom_range(0, 11) == 0);
            cop_insn_ack = ($urandom_range(0, 2) == 0);
            cop_insn_rsp = ($urandom_range(0, 3) == 0);
            cop_wen      = 1'($urandom_range(0, 1));
            cop_waddr    = 5'($urandom_range(0, 31));
            cop_wdata    = $urandom;
            cop_result   = 3'($urandom_range(0, 5));
            wb_ready     = 1'($urandom_range(0, 1));
            g_reset      = ($urandom_range(0, 149) == 0);
            tick();
        end
        g_reset = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/scarv_cop_dispatch.md
SCARV_COP_DISPATCH -- requirements
Module: scarv_cop_dispatch

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of WAIT cycles before a forced timeout completion.
REQ-002 SHALL have parameter TCW, default 8, meaning the timeout counter width.
REQ-003 g_clk  in  1  single clock; all logic rising-edge.
REQ-004 g_reset  in  1  reset; synchronous and active-high.
REQ-005 hst_valid / hst_ready  in/out  1/1  host-side instruction offer and accept.
REQ-006 hst_insn / hst_rs1  in  32/32  encoded instruction and RS1 operand.
REQ-007 hst_abort  in  1  host abort of the in-flight instruction.
REQ-008 cpu_insn_req / cop_insn_ack  out/in  1/1  coprocessor issue handshake.
REQ-009 cpu_insn_enc / cpu_rs1  out  32/32  issued instruction and operand.
REQ-010 cpu_abort_req  out  1  abort request to the coprocessor.
REQ-011 cop_insn_rsp / cpu_insn_ack  in/out  1/1  coprocessor completion handshake.
REQ-012 cop_wen, cop_waddr, cop_wdata, cop_result  in  1/5/32/3  coprocessor writeback and result.
REQ-013 wb_valid / wb_ready  out/in  1/1  host writeback handshake.
REQ-014 wb_wen, wb_addr, wb_data, wb_result  out  1/5/32/3  registered writeback payload.

Function
REQ-015 The FSM SHALL have the states IDLE, ISSUE, WAIT and WB, with a single instruction in flight.
REQ-016 hst_ready = (state==IDLE); on hst_valid&&hst_ready, the block SHALL capture insn and rs1 and go to ISSUE next cycle.
REQ-017 In ISSUE, cpu_insn_req=1 and enc/rs1 SHALL hold stable until cpu_insn_req&&cop_insn_ack, then go to WAIT.
REQ-018 cpu_insn_req SHALL never drop in ISSUE except on abort.
REQ-019 In WAIT, cpu_insn_ack=1; on cop_insn_rsp&&cpu_insn_ack, the block SHALL capture wen/waddr/wdata/result and go to WB.
REQ-020 cpu_insn_ack SHALL be 0 in all other states; a cop_insn_rsp outside WAIT SHALL be ignored.
REQ-021 In WB, wb_valid=1 and the payload SHALL be stable; on wb_ready, the FSM SHALL go to IDLE.
REQ-022 Minimum host-to-writeback latency SHALL be 3 cycles: accept, ack same cycle in ISSUE, rsp in first WAIT cycle.
REQ-023 Timeout: the counter SHALL clear on WAIT entry and increment each WAIT cycle without rsp.
REQ-024 When the counter reaches TIMEOUT, the FSM SHALL go to WB with wb_result=RES_TIMEOUT, wb_wen=0 and wb_data=0.
REQ-025 The counter SHALL saturate and never wrap.
REQ-026 hst_abort in ISSUE SHALL drop cpu_insn_req next cycle and return to IDLE with no writeback.
REQ-027 If cop_insn_ack coincides with hst_abort, the ack SHALL win and the abort SHALL be treated as arriving in WAIT.
REQ-028 hst_abort in WAIT SHALL pulse cpu_abort_req for exactly 1 cycle and set an abort flag.
REQ-029 The following rsp SHALL be consumed (cpu_insn_ack) but completed with wb_result=RES_ABORT and wb_wen=0.
REQ-030 hst_abort in IDLE or WB SHALL be ignored.
REQ-031 If rsp and timeout coincide, the rsp SHALL win.

Reset
REQ-032 While g_reset=1 at a clock edge, the block SHALL enter IDLE and clear the counter and abort flag.
REQ-033 All outputs SHALL be 0 after reset except hst_ready=1.
REQ-034 Reset mid-operation SHALL discard the in-flight instruction with no writeback and no cpu_abort_req.

Structure
REQ-035 The shared package scarv_cop_pkg SHALL hold the FSM state encoding and the 3-bit result codes RES_OK=0, RES_ABORT=6, RES_TIMEOUT=7.
REQ-036 The block SHALL be one module; the timeout counter MAY be the sub-module scarv_cop_dispatch_timer.

Verification
REQ-037 Instruction 0x0000_002B, rs1 0xDEADBEEF, ack immediate, rsp with wen=1, waddr=5, wdata=0x1234 -> wb_valid on cycle 3 with wb_addr=5, wb_data=0x1234, wb_result=0.
REQ-038 cop_insn_ack withheld 4 cycles -> cpu_insn_req high for 5 cycles with enc/rs1 unchanged.
REQ-039 TIMEOUT=4, no rsp -> wb_result=7, wb_wen=0 after 4 WAIT cycles; a later rsp is ignored.
REQ-040 hst_abort in the 2nd WAIT cycle -> one-cycle cpu_abort_req; rsp with wen=1 -> wb_result=6, wb_wen=0.
REQ-041 wb_ready held low 10 cycles -> payload stable and hst_ready=0 throughout; next instruction accepted the cycle after wb_ready.
REQ-042 g_reset asserted in WAIT -> IDLE next cycle, wb_valid=0, cpu_abort_req=0, hst_ready=1.
